// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: combinational decode of every immediate
// format, registered behind a valid/ready stage with an optional one-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds its payload stable while valid is high and ready is low.

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] shamt5, shamt6, zimm;

    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
    assign shamt5 = XLEN'(in_instr[24:20]);
    assign shamt6 = XLEN'(in_instr[25:20]);
    assign zimm   = XLEN'(in_instr[19:15]);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    always_comb begin
        opcode   = in_instr[6:0];
        funct3   = in_instr[14:12];
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        dec_imm  = '0;
        dec_fmt  = FMT_R;
        dec_ill  = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            7'b0010011: begin
                dec_fmt = FMT_I;
                if (is_shift) dec_imm = (XLEN == 64) ? shamt6 : shamt5;
                else          dec_imm = imm_i;
            end
            7'b0011011: begin
                // Word shifts only ever encode a 5-bit shift amount.
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = is_shift ? shamt5 : imm_i;
                end else begin
                    dec_fmt = FMT_ILL;
                    dec_ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = imm_s;
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = imm_j;
            end
            7'b1110011: begin
                dec_fmt = funct3[2] ? FMT_Z : FMT_I;
                dec_imm = funct3[2] ? zimm : imm_i;
            end
            7'b0110011, 7'b0001111: begin
                dec_fmt = FMT_R;
            end
            7'b0111011: begin
                if (XLEN != 64) begin
                    dec_fmt = FMT_ILL;
                    dec_ill = 1'b1;
                end
            end
            default: begin
                dec_fmt = FMT_ILL;
                dec_ill = 1'b1;
            end
        endcase
    end

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_fmt_q, out_fmt_d;
    logic             out_ill_q, out_ill_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_fmt_q, skid_fmt_d;
    logic             skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_ready_q, in_ready_d;
    logic             out_free, in_fire;

    assign out_free = !out_valid_q || out_ready;
    // Ready is forced low while reset is held, whatever the registered value is.
    assign in_ready = !rst && ((SKID != 0) ? in_ready_q : out_free);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        skid_tag_d   = skid_tag_q;
        in_ready_d   = in_ready_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_imm_d    = '0;
            out_fmt_d    = FMT_R;
            out_ill_d    = 1'b0;
            skid_valid_d = 1'b0;
            in_ready_d   = 1'b1;
        end else if (SKID != 0) begin
            if (out_free) begin
                // The skid entry is older than anything on the input, so it goes first.
                if (skid_valid_q) begin
                    out_imm_d    = skid_imm_q;
                    out_fmt_d    = skid_fmt_q;
                    out_ill_d    = skid_ill_q;
                    out_tag_d    = skid_tag_q;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_imm_d   = dec_imm;
                    out_fmt_d   = dec_fmt;
                    out_ill_d   = dec_ill;
                    out_tag_d   = in_tag;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_fmt_d   = dec_fmt;
                skid_ill_d   = dec_ill;
                skid_tag_d   = in_tag;
            end
            in_ready_d = !skid_valid_d;
        end else begin
            if (in_fire) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_ill_d   = dec_ill;
                out_tag_d   = in_tag;
            end else if (out_free) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_R;
            out_ill_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_R;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_ill_q;
    assign out_tag     = out_tag_q;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage.
- Decodes every RV32I/RV64I immediate format, including shift-amount and CSR zimm forms, and flags unknown opcodes.
- Registers the result behind a valid/ready handshake with an optional skid buffer, so decode can stall or flush without losing instructions.
- Carries a sideband tag (PC) alongside each instruction.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction.
- SKID, 1, 1 = one-entry skid buffer with registered in_ready; 0 = single stage with combinational in_ready.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  instruction valid.
- in_ready  output  1  stage can accept an instruction.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag (PC).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_imm  output  XLEN  sign- or zero-extended immediate.
- out_fmt  output  3  format code: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 illegal.
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the instruction on the output.

Behaviour:
- Decode is combinational on in_instr; results are registered. Latency is 1 cycle from an accepted input to out_valid.
- Opcode-to-immediate mapping:
  - 0000011, 0010011, 1100111: I-type, sext(instr[31:20]).
  - 0010011 with funct3 001/101: zero-extended shamt; instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; fmt I.
  - 0100011: S-type, sext({instr[31:25], instr[11:7]}).
  - 1100011: B-type, sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111: U-type, sext({instr[31:12], 12'b0}) to XLEN.
  - 1101111: J-type, sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 1110011 with funct3[2]=1: Z, zext(instr[19:15]). With funct3[2]=0: fmt I, sext(instr[31:20]).
  - 0110011, 0111011 (XLEN=64 only), 0001111: fmt 0, imm 0.
  - 0011011 (XLEN=64 only): I-type, with the shamt rule above using instr[24:20].
  - Any other opcode: imm 0, fmt 7, out_illegal=1. No X ever reaches the outputs.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - SKID=0: in_ready = !out_valid || out_ready.
  - SKID=1: in_ready = !skid_valid, registered.
    - If the output stage is held (out_valid && !out_ready) and an input is accepted, the input goes to the skid entry; in_ready drops on the next cycle.
    - When the output transfers, the skid entry moves into the output stage in the same edge; in_ready rises the following cycle.
    - Simultaneous output transfer and new input with the skid empty: the new input loads the output stage directly.
  - Order is always preserved. No instruction is dropped or duplicated.
- Reset (asynchronous):
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, skid_valid=0.
  - in_ready=0 while rst is asserted; in_ready=1 on the first cycle after release.
  - Reset mid-transfer discards both entries.
- Flush:
  - Clears out_valid and skid_valid on the next edge and zeroes out_imm, out_fmt, out_illegal.
  - Flush wins over a simultaneous in_valid; that input is dropped.
  - in_ready=1 on the cycle after flush.
- Outputs hold stable while out_valid && !out_ready.

Test Plan:
1. XLEN=32. in_instr=0xFFF00093 (addi x1,x0,-1), tag=0x100, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1, out_tag=0x100.
2. Back-to-back 0xFE112E23 (sw x1,-4(x2)) then 0xFE000CE3 (beq x0,x0,-8) -> consecutive outputs 0xFFFFFFFC fmt 2, then 0xFFFFFFF8 fmt 3, both with out_illegal=0.
3. SKID=1, out_ready=0, three inputs offered on consecutive cycles:
   - First lands in the output stage, second in the skid entry.
   - in_ready=0 from cycle 3, so the third is held by the source.
   - Raise out_ready -> all three emerge in order, one per cycle; in_ready returns to 1.
4. in_instr=0x0000007F -> out_fmt=7, out_illegal=1, out_imm=0. Then 0x00105073 (csrrwi x0,1,0) -> fmt 6, imm 0x0.
5. Flush with the output and skid both full and in_valid=1 -> next cycle out_valid=0 and in_ready=1. Assert rst mid-stream -> outputs 0 immediately, without waiting for a clock edge.
6. XLEN=64:
   - 0x03F09093 (slli x1,x1,63) -> imm 63.
   - 0x800000B7 (lui x1,0x80000) -> imm 0xFFFFFFFF80000000.
